sipo_word_deframer: RTL and testbench

// - Deserialiser stage downstream of the D_ff serial chain. Collects the

---
 rtl/sipo_word_deframer.sv | 150 +++++++++++++++
 tb/tb_sipo_word_deframer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_word_deframer.sv
// Serial-to-parallel word deframer with a valid/ready holding register and sticky overrun.
// Optional even-parity frame check is enabled by defining SIPO_PARITY_CHK_EN.
module sipo_word_deframer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             parity_err,
  output logic [5:0]       bit_cnt
);

  typedef enum logic [0:0] {ST_SHIFT = 1'b0, ST_PAR = 1'b1} state_t;

  localparam logic [5:0] LAST_DATA = 6'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvld_q, dvld_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             perr_new;

  assign shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], din} : {din, sr_q[WIDTH-1:1]};

  // Frame assembly: sync_clr outranks any concurrent serial bit.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    word     = shifted;
    perr_new = 1'b0;
    if (sync_clr) begin
      sr_d    = '0;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end else if (din_valid) begin
      case (state_q)
        ST_SHIFT: begin
          sr_d = shifted;
          if (cnt_q == LAST_DATA) begin
`ifdef SIPO_PARITY_CHK_EN
            cnt_d   = cnt_q + 6'd1;
            state_d = ST_PAR;
`else
            cnt_d    = '0;
            complete = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        ST_PAR: begin
          // Parity bit closes the frame without entering the shift register.
          word     = sr_q;
          perr_new = ^{sr_q, din};
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      endcase
    end
  end

  // Holding register: a word completing while the consumer stalls is dropped.
  always_comb begin
    dout_d = dout_q;
    dvld_d = dvld_q;
    ovr_d  = ovr_q;
    if (complete) begin
      if (!dvld_q || dout_ready) begin
        dout_d = word;
        dvld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (dvld_q && dout_ready) begin
      dvld_d = 1'b0;
    end
    if (clr_overrun && !(complete && dvld_q && !dout_ready)) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SHIFT;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SIPO_PARITY_CHK_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (complete && (!dvld_q || dout_ready)) begin
      perr_d = perr_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  logic perr_unused;
  assign perr_unused = perr_new;
  assign parity_err  = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dvld_q;
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_word_deframer.sv
// Randomised and directed bench for sipo_word_deframer; MSB-first and LSB-first
// instances share stimulus and are compared against a frame-level reference model.
module tb_sipo_word_deframer;
  localparam int W = 8;
`ifdef SIPO_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0, din_valid = 1'b0, sync_clr = 1'b0;
  logic dout_ready = 1'b0, clr_overrun = 1'b0;
  logic [W-1:0] dout_m, dout_l;
  logic dv_m, dv_l, ov_m, ov_l, pe_m, pe_l;
  logic [5:0] bc_m, bc_l;

  sipo_word_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync_clr(sync_clr),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready), .overrun(ov_m),
    .clr_overrun(clr_overrun), .parity_err(pe_m), .bit_cnt(bc_m));

  sipo_word_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync_clr(sync_clr),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready), .overrun(ov_l),
    .clr_overrun(clr_overrun), .parity_err(pe_l), .bit_cnt(bc_l));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the current frame in arrival order
  int           nbits;
  logic         fbits [0:W-1];
  logic [W-1:0] e_dout_m, e_dout_l;
  logic         e_dv, e_ov, e_pe;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    nbits    = 0;
    e_dout_m = '0;
    e_dout_l = '0;
    e_dv     = 1'b0;
    e_ov     = 1'b0;
    e_pe     = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic v, input logic sc,
                            input logic rdy, input logic clr);
    logic complete = 1'b0;
    logic par = 1'b0;
    logic drop = 1'b0;
    logic [W-1:0] wm = '0;
    logic [W-1:0] wl = '0;
    if (sc) begin
      nbits = 0;
    end else if (v) begin
      if (nbits < W) begin
        fbits[nbits] = d;
        nbits++;
        if (nbits == W && !PAR_EN) complete = 1'b1;
      end else begin
        par = d;
        complete = 1'b1;
      end
    end
    if (complete) begin
      for (int i = 0; i < W; i++) begin
        wm[W-1-i] = fbits[i];
        wl[i]     = fbits[i];
      end
      nbits = 0;
      if (!e_dv || rdy) begin
        e_dout_m = wm;
        e_dout_l = wl;
        e_dv     = 1'b1;
        e_pe     = PAR_EN ? ((^wm) ^ par) : 1'b0;
      end else begin
        drop = 1'b1;
      end
    end else if (e_dv && rdy) begin
      e_dv = 1'b0;
    end
    if (drop) e_ov = 1'b1;
    else if (clr) e_ov = 1'b0;
  endtask

  task automatic check_all();
    check_val("dout_msb", dout_m, e_dout_m);
    check_val("dout_lsb", dout_l, e_dout_l);
    check_val("dout_valid_msb", dv_m, e_dv);
    check_val("dout_valid_lsb", dv_l, e_dv);
    check_val("overrun_msb", ov_m, e_ov);
    check_val("overrun_lsb", ov_l, e_ov);
    check_val("parity_err_msb", pe_m, e_pe);
    check_val("parity_err_lsb", pe_l, e_pe);
    check_val("bit_cnt_msb", bc_m, nbits);
    check_val("bit_cnt_lsb", bc_l, nbits);
  endtask

  task automatic cycle(input logic d, input logic v, input logic sc,
                       input logic rdy, input logic clr);
    din = d; din_valid = v; sync_clr = sc; dout_ready = rdy; clr_overrun = clr;
    model_step(d, v, sc, rdy, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic par,
                            input logic rdy, input logic clr_last);
    for (int i = W - 1; i >= 0; i--) begin
      cycle(w[i], 1'b1, 1'b0, rdy, (clr_last && i == 0 && !PAR_EN));
    end
    if (PAR_EN) cycle(par, 1'b1, 1'b0, rdy, clr_last);
  endtask

  initial begin
    model_reset();
    // Reset held with din toggling
    rst = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      @(posedge clk);
      #1;
      check_val("rst_dout", dout_m, 0);
      check_val("rst_dout_valid", dv_m, 0);
      check_val("rst_overrun", ov_m, 0);
      check_val("rst_parity_err", pe_m, 0);
      check_val("rst_bit_cnt", bc_m, 0);
    end
    din_valid = 1'b0;
    rst = 1'b1;

    // First word after reset
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check_val("a5_dout", dout_m, 8'hA5);
    check_val("a5_valid", dv_m, 1);
    check_val("a5_bit_cnt", bc_m, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back streaming with consumer always ready
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check_val("b2b_first", dout_m, 8'h3C);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    check_val("b2b_second", dout_m, 8'hC3);
    check_val("b2b_overrun", ov_m, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun and its clear priority
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    check_val("ovr_dout_held", dout_m, 8'h11);
    check_val("ovr_set", ov_m, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("ovr_cleared", ov_m, 0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    check_val("ovr_set_wins", ov_m, 1);
    check_val("ovr_dout_still", dout_m, 8'h11);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Resync mid-frame
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(i[0], 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("resync_bit_cnt", bc_m, 0);
    check_val("resync_held", dout_m, 8'h5A);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    check_val("resync_word", dout_m, 8'h0F);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first ordering, then asynchronous reset mid-frame
    send_frame(8'h80, 1'b1, 1'b0, 1'b0);
    check_val("lsb_first_word", dout_l, 8'h01);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_val("async_rst_valid", dv_m, 0);
    check_val("async_rst_bit_cnt", bc_m, 0);
    check_val("async_rst_valid_lsb", dv_l, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    check_all();

`ifdef SIPO_PARITY_CHK_EN
    for (int i = W - 1; i >= 0; i--) cycle(W'(8'hA5) >> i, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("par_state_bit_cnt", bc_m, 8);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("par_good", pe_m, 0);
    check_val("par_good_word", dout_m, 8'hA5);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_val("par_bad", pe_m, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      cycle(1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0),
            1'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
